// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for a registered-read instruction memory.
// Pairs each returned word with its PC, handling stall, zero-bubble redirect and halt.
module fetch_sequencer #(
    parameter int unsigned MEM_DEPTH = 32,
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_valid,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      instr_out,
    output logic [31:0]      pc_out,
    output logic             instr_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BUBBLE = 2'd0,
        RUN    = 2'd1,
        HALT   = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic             resp_live_q, resp_live_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic issue;
    logic accept;
    logic addr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BUBBLE;
            fetch_pc_q  <= RESET_PC;
            resp_pc_q   <= '0;
            resp_live_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            resp_live_q <= resp_live_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        instr_valid = resp_live_q && (state_q != HALT);
        instr_out   = instr_valid ? imem_data : '0;
        pc_out      = resp_pc_q;
        halted      = (state_q == HALT);
        fetch_count = count_q;

        // Stall and HALT re-present the held address so imem_data stays stable.
        if (branch_valid) begin
            imem_addr = branch_target;
        end else if (stall || state_q == HALT) begin
            imem_addr = resp_pc_q;
        end else begin
            imem_addr = fetch_pc_q;
        end

        addr_ok = (imem_addr < DEPTH);
        issue   = branch_valid || (state_q != HALT && !stall);
        accept  = instr_valid && !stall && !branch_valid;
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        resp_live_d = resp_live_q;
        count_d     = count_q;

        if (issue) begin
            resp_pc_d   = imem_addr;
            fetch_pc_d  = imem_addr + 32'd1;
            resp_live_d = addr_ok;
            state_d     = addr_ok ? RUN : HALT;
        end

        if (accept && count_q != '1) begin
            count_d = count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer against a registered-read memory model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .MEM_DEPTH(32),
        .RESET_PC (32'd0),
        .CNT_W    (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    function automatic logic [31:0] word(input int unsigned a);
        return 32'hA500_0000 | 32'(a * 3 + 1);
    endfunction

    // Out-of-range reads return garbage so masking is exercised.
    always_ff @(posedge clk) begin
        if (imem_addr < 32'd32) imem_data <= word(imem_addr);
        else                    imem_data <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input int unsigned pc, input int unsigned cnt);
        chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
        chk({tag, ".pc"}, pc_out, 32'(pc));
        chk({tag, ".instr"}, instr_out, word(pc));
        chk({tag, ".count"}, 32'(fetch_count), 32'(cnt));
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_valid = 1'b0; branch_target = '0;
        tick(); tick();
        chk("rst.valid", 32'(instr_valid), 32'd0);
        chk("rst.instr", instr_out, 32'd0);
        chk("rst.pc", pc_out, 32'd0);
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.count", 32'(fetch_count), 32'd0);
        chk("rst.addr", imem_addr, 32'd0);

        rst_n = 1'b1;
        chk("c0.valid", 32'(instr_valid), 32'd0);
        chk("c0.addr", imem_addr, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_fetch("seq", i, i);
        end
        tick();
        chk_fetch("seq5", 5, 5);

        stall = 1'b1;
        #1;
        chk("stall.addr", imem_addr, 32'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_fetch("stall", 5, 5);
            chk("stall.addr_h", imem_addr, 32'd5);
        end
        stall = 1'b0;
        tick();
        chk_fetch("unstall", 6, 6);

        for (int i = 7; i <= 12; i++) tick();
        chk_fetch("pre_br", 12, 12);
        branch_valid = 1'b1; branch_target = 32'd1;
        #1;
        chk("br.addr", imem_addr, 32'd1);
        tick();
        branch_valid = 1'b0;
        chk_fetch("br1", 1, 12);
        tick();
        chk_fetch("br2", 2, 13);
        tick();
        chk_fetch("br3", 3, 14);

        branch_valid = 1'b1; stall = 1'b1; branch_target = 32'd14;
        tick();
        branch_valid = 1'b0; stall = 1'b0;
        chk_fetch("brstall", 14, 14);

        for (int i = 15; i <= 31; i++) tick();
        chk_fetch("last", 31, 31);
        tick();
        chk("halt.valid", 32'(instr_valid), 32'd0);
        chk("halt.halted", 32'(halted), 32'd1);
        chk("halt.instr", instr_out, 32'd0);
        chk("halt.count", 32'(fetch_count), 32'd32);
        tick();
        chk("halt2.halted", 32'(halted), 32'd1);
        chk("halt2.instr", instr_out, 32'd0);
        chk("halt2.addr", imem_addr, 32'd32);
        chk("halt2.count", 32'(fetch_count), 32'd32);

        branch_valid = 1'b1; branch_target = 32'd40;
        tick();
        branch_valid = 1'b0;
        chk("br40.halted", 32'(halted), 32'd1);
        chk("br40.valid", 32'(instr_valid), 32'd0);
        chk("br40.instr", instr_out, 32'd0);

        branch_valid = 1'b1; branch_target = 32'd0;
        tick();
        branch_valid = 1'b0;
        chk("br0.halted", 32'(halted), 32'd0);
        chk_fetch("br0", 0, 32);
        for (int i = 1; i <= 7; i++) tick();
        chk_fetch("pre_rst", 7, 39);

        rst_n = 1'b0;
        #1;
        chk("mrst.valid", 32'(instr_valid), 32'd0);
        chk("mrst.count", 32'(fetch_count), 32'd0);
        chk("mrst.addr", imem_addr, 32'd0);
        chk("mrst.instr", instr_out, 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst.bubble", 32'(instr_valid), 32'd0);
        tick();
        chk_fetch("refetch0", 0, 0);
        tick();
        chk_fetch("refetch1", 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
